freecell_move_sequencer: RTL

//  Drives the freecell player's source/dest move interface from a queue of moves

---
 rtl/freecell_move_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/freecell_move_sequencer.sv
// Queues host-supplied moves and issues them one at a time to the freecell player,
// separating moves with idle gaps and reporting done/won status and move counts.
module freecell_move_sequencer #(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 1,
  parameter int COUNT_W    = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [3:0]         push_source,
  input  logic [3:0]         push_dest,
  input  logic               start,
  input  logic               win,
  output logic [3:0]         source,
  output logic [3:0]         dest,
  output logic               busy,
  output logic               done,
  output logic               won,
  output logic [COUNT_W-1:0] move_count,
  output logic [COUNT_W-1:0] bad_count,
  output logic [LW-1:0]      fifo_level
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0]         IDLE_CODE = 4'b1100;
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

  logic [7:0]         mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ready_q, ready_d;
  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [3:0]         src_q, src_d, dst_q, dst_d;
  logic               busy_q, busy_d, done_q, done_d, won_q, won_d;
  logic [COUNT_W-1:0] mcnt_q, mcnt_d, bcnt_q, bcnt_d;

  logic       push_fire_s, pop_s, fifo_empty_s, head_bad_s, load_head_s;
  logic [7:0] head_s;

  assign push_fire_s  = push_valid && ready_q;
  assign pop_s        = (state_q == S_ISSUE);
  assign fifo_empty_s = (level_q == '0);
  assign head_s       = mem_q[rd_ptr_q];
  // A home code (11xx) as source can never be a legal move.
  assign head_bad_s   = (head_s[7:6] == 2'b11);

  // FIFO pointer, level and ready bookkeeping.
  always_comb begin
    wr_ptr_d = push_fire_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_fire_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ready_d = (level_d != LW'(DEPTH));
  end

  // Sequencer FSM, counters and next output code.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    won_d       = won_q;
    mcnt_d      = mcnt_q;
    bcnt_d      = bcnt_q;
    load_head_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcnt_d = '0;
          bcnt_d = '0;
          won_d  = 1'b0;
          if (!fifo_empty_s) begin
            state_d     = S_ISSUE;
            load_head_s = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        if (head_bad_s) begin
          bcnt_d = (bcnt_q == CNT_MAX) ? bcnt_q : bcnt_q + COUNT_W'(1);
        end else begin
          mcnt_d = (mcnt_q == CNT_MAX) ? mcnt_q : mcnt_q + COUNT_W'(1);
        end
        gap_d   = GW'(GAP_CYCLES - 1);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (win) begin
          state_d = S_DONE;
          won_d   = 1'b1;
        end else if (fifo_empty_s) begin
          state_d = S_DONE;
          won_d   = 1'b0;
        end else begin
          state_d     = S_ISSUE;
          load_head_s = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_head_s && !head_bad_s) begin
      src_d = head_s[7:4];
      dst_d = head_s[3:0];
    end else begin
      src_d = IDLE_CODE;
      dst_d = IDLE_CODE;
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_ISSUE) || (state_d == S_GAP);
  end

  // Move storage; contents need no reset since level gates every read.
  always_ff @(posedge clock) begin
    if (push_fire_s) begin
      mem_q[wr_ptr_q] <= {push_source, push_dest};
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
      state_q  <= S_IDLE;
      gap_q    <= '0;
      src_q    <= IDLE_CODE;
      dst_q    <= IDLE_CODE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      won_q    <= 1'b0;
      mcnt_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      won_q    <= won_d;
      mcnt_q   <= mcnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign push_ready = ready_q;
  assign source     = src_q;
  assign dest       = dst_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign won        = won_q;
  assign move_count = mcnt_q;
  assign bad_count  = bcnt_q;
  assign fifo_level = level_q;

endmodule
